// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared numeric constants for the multiply scheduler
package constants_pkg;

  // Default fixed latency of the pipelined multiplier (legal 2..8)
  localparam int MUL_LAT_DEFAULT = 4;

  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 4;
  localparam int PERF_W    = 32;

endpackage

// File: rtl/structure_pkg.sv
// rtl/structure_pkg.sv - slot record and stall cause encoding for the multiply scheduler
package structure_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } mul_slot_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_WB   = 2'd2
  } stall_cause_e;

  // True when a live slot will write a non-zero register equal to idx
  function automatic logic slot_hits(input mul_slot_t s, input logic [4:0] idx);
    return s.valid && (s.rd != 5'd0) && (s.rd == idx);
  endfunction

endpackage

// File: rtl/mul_slot_tracker.sv
// rtl/mul_slot_tracker.sv - shift register of in-flight multiplies plus occupancy counter
module mul_slot_tracker
  import structure_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic                    issue,
  input  logic [4:0]              issue_rd,
  output mul_slot_t [MUL_LAT:1]   slots,
  output logic [3:0]              inflight_cnt
);

  mul_slot_t new_slot;
  logic      do_issue;
  logic      do_retire;

  assign new_slot  = issue ? {1'b1, issue_rd} : '0;
  assign do_issue  = issue & advance;
  // Whatever sits in the last slot drops out on an advancing edge
  assign do_retire = slots[MUL_LAT].valid & advance;

  // Slot pipeline: shift toward slot MUL_LAT when advancing, hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots <= '0;
    end else if (advance) begin
      slots <= {slots[MUL_LAT-1:1], new_slot};
    end
  end

  // Occupancy: +1 on issue, -1 on retire, unchanged when both or neither
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_cnt <= 4'd0;
    end else begin
      case ({do_issue, do_retire})
        2'b10:   inflight_cnt <= inflight_cnt + 4'd1;
        2'b01:   inflight_cnt <= inflight_cnt - 4'd1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// rtl/mul_scheduler.sv - multiply issue/hazard scheduler; MUL_SCHED_PERF_EN adds perf counters
module mul_scheduler
  import constants_pkg::*;
  import structure_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic        dec_is_m,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_uses_rs1,
  input  logic        dec_uses_rs2,
  input  logic        stall_in,
  input  logic        br_kill,
  output logic        mul_issue,
  output logic        mul_advance,
  output logic        wb_sel_mul,
  output logic [4:0]  wb_rd,
  output logic        dec_stall,
  output logic [1:0]  stall_cause,
`ifdef MUL_SCHED_PERF_EN
  output logic [3:0]  inflight_cnt,
  output logic [31:0] perf_mul_issued,
  output logic [31:0] perf_raw_stall,
  output logic [31:0] perf_wb_stall
`else
  output logic [3:0]  inflight_cnt
`endif
);

  mul_slot_t [MUL_LAT:1] slots;
  logic                  hazard_raw;
  logic                  hazard_wb;
  stall_cause_e          cause;

  assign mul_advance = ~stall_in;

  mul_slot_tracker #(.MUL_LAT(MUL_LAT)) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .advance      (mul_advance),
    .issue        (mul_issue),
    .issue_rd     (dec_rd),
    .slots        (slots),
    .inflight_cnt (inflight_cnt)
  );

  // Dependency check of the decode instruction against every in-flight multiply
  always_comb begin
    hazard_raw = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      if ((dec_uses_rs1 && slot_hits(slots[k], dec_rs1)) ||
          (dec_uses_rs2 && slot_hits(slots[k], dec_rs2)) ||
          slot_hits(slots[k], dec_rd)) begin
        hazard_raw = 1'b1;
      end
    end
    hazard_raw = hazard_raw & dec_valid;
  end

  // A single-cycle op issued now would hit the memory stage alongside slot MUL_LAT-1
  assign hazard_wb = dec_valid & ~dec_is_m & slots[MUL_LAT-1].valid;

  // Stall decision and cause; RAW takes priority when both hazards are present
  always_comb begin
    dec_stall = ~br_kill & (hazard_raw | hazard_wb);
    cause     = CAUSE_NONE;
    if (dec_stall) begin
      cause = hazard_raw ? CAUSE_RAW : CAUSE_WB;
    end
  end

  assign stall_cause = cause;
  // Gated with rst so nothing launches while reset is held
  assign mul_issue   = rst & dec_valid & dec_is_m & ~dec_stall & ~stall_in & ~br_kill;
  assign wb_sel_mul  = slots[MUL_LAT].valid;
  assign wb_rd       = slots[MUL_LAT].valid ? slots[MUL_LAT].rd : 5'd0;

`ifdef MUL_SCHED_PERF_EN
  // Saturating event counters: issues, RAW stall cycles, writeback stall cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_mul_issued <= '0;
      perf_raw_stall  <= '0;
      perf_wb_stall   <= '0;
    end else begin
      if (mul_issue && perf_mul_issued != '1) perf_mul_issued <= perf_mul_issued + 32'd1;
      if (cause == CAUSE_RAW && perf_raw_stall != '1) perf_raw_stall <= perf_raw_stall + 32'd1;
      if (cause == CAUSE_WB && perf_wb_stall != '1) perf_wb_stall <= perf_wb_stall + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_mul_scheduler.sv
// tb/tb_mul_scheduler.sv - directed self-checking bench for mul_scheduler
module tb_mul_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_is_m, dec_uses_rs1, dec_uses_rs2;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic       stall_in, br_kill;
  logic       mul_issue, mul_advance, wb_sel_mul, dec_stall;
  logic [4:0] wb_rd;
  logic [1:0] stall_cause;
  logic [3:0] inflight_cnt;
`ifdef MUL_SCHED_PERF_EN
  logic [31:0] perf_mul_issued, perf_raw_stall, perf_wb_stall;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mul_scheduler #(.MUL_LAT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_is_m     (dec_is_m),
    .dec_rd       (dec_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_uses_rs1 (dec_uses_rs1),
    .dec_uses_rs2 (dec_uses_rs2),
    .stall_in     (stall_in),
    .br_kill      (br_kill),
    .mul_issue    (mul_issue),
    .mul_advance  (mul_advance),
    .wb_sel_mul   (wb_sel_mul),
    .wb_rd        (wb_rd),
    .dec_stall    (dec_stall),
    .stall_cause  (stall_cause),
`ifdef MUL_SCHED_PERF_EN
    .inflight_cnt    (inflight_cnt),
    .perf_mul_issued (perf_mul_issued),
    .perf_raw_stall  (perf_raw_stall),
    .perf_wb_stall   (perf_wb_stall)
`else
    .inflight_cnt (inflight_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2);
    dec_valid = v; dec_is_m = m; dec_rd = rd;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_uses_rs1 = u1; dec_uses_rs2 = u2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; br_kill = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle(); next_cycle();
    #4;
    check("rst_issue", mul_issue, 0);
    check("rst_cnt", inflight_cnt, 0);
    check("rst_wbsel", wb_sel_mul, 0);
    check("rst_wbrd", wb_rd, 0);
    next_cycle();
    rst = 1'b1; idle();
    next_cycle();

    // Single mul x5: retires at cycle 4, count 1,1,1,1,0
    drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    #4; check("t1_issue", mul_issue, 1);
    next_cycle(); idle();
    for (int c = 1; c <= 5; c++) begin
      #4;
      check($sformatf("t1_cnt_c%0d", c), inflight_cnt, (c <= 4) ? 1 : 0);
      check($sformatf("t1_wbsel_c%0d", c), wb_sel_mul, (c == 4) ? 1 : 0);
      if (c == 4) check("t1_wbrd", wb_rd, 5);
      next_cycle();
    end

    // RAW: add reading x5 stalls cycles 1..4, proceeds at cycle 5
    drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd8, 5'd5, 5'd0, 1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      #4;
      check($sformatf("t2_stall_c%0d", c), dec_stall, (c <= 4) ? 1 : 0);
      check($sformatf("t2_cause_c%0d", c), stall_cause, (c <= 4) ? 1 : 0);
      next_cycle();
    end
    idle();

    // Writeback collision: independent add at cycle 3 stalls exactly one cycle
    drive(1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle(); idle(); next_cycle(); next_cycle();
    drive(1'b1, 1'b0, 5'd9, 5'd10, 5'd11, 1'b1, 1'b1);
    #4; check("t3_stall_c3", dec_stall, 1); check("t3_cause_c3", stall_cause, 2);
    next_cycle();
    #4; check("t3_stall_c4", dec_stall, 0); check("t3_cause_c4", stall_cause, 0);
    check("t3_wbrd_c4", wb_rd, 6);
    next_cycle(); idle();

    // Four back-to-back muls x1..x4
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 5'(c + 1), 5'd0, 5'd0, 1'b0, 1'b0);
      #4;
      check($sformatf("t4_issue_c%0d", c), mul_issue, 1);
      check($sformatf("t4_stall_c%0d", c), dec_stall, 0);
      next_cycle();
    end
    idle();
    for (int c = 4; c <= 8; c++) begin
      #4;
      check($sformatf("t4_wbsel_c%0d", c), wb_sel_mul, (c <= 7) ? 1 : 0);
      check($sformatf("t4_wbrd_c%0d", c), wb_rd, (c <= 7) ? c - 3 : 0);
      check($sformatf("t4_cnt_c%0d", c), inflight_cnt, (c <= 7) ? 8 - c : 0);
      next_cycle();
    end

    // Back-pressure: x7 held in slot 2 for three cycles, retires at cycle 7
    drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle(); idle(); next_cycle();
    stall_in = 1'b1;
    #4; check("t5_adv", mul_advance, 0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0);
    #4; check("t5_issue_stalled", mul_issue, 0); check("t5_cnt", inflight_cnt, 1);
    next_cycle(); idle();
    #4; check("t5_wbsel_c4", wb_sel_mul, 0);
    next_cycle(); stall_in = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      #4;
      check($sformatf("t5_wbsel_c%0d", c), wb_sel_mul, (c == 7) ? 1 : 0);
      if (c == 7) check("t5_wbrd", wb_rd, 7);
      next_cycle();
    end

    // Branch kill: mul in decode dropped, hazard suppressed, older mul survives
    drive(1'b1, 1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd14, 5'd13, 5'd0, 1'b1, 1'b0);
    br_kill = 1'b1;
    #4; check("t6_kill_issue", mul_issue, 0); check("t6_kill_stall", dec_stall, 0);
    next_cycle(); br_kill = 1'b0; idle();
    #4; check("t6_cnt", inflight_cnt, 1);
    next_cycle(); next_cycle();
    #4; check("t6_wbrd_c4", wb_rd, 13);
    next_cycle();
    #4; check("t6_wbsel_c5", wb_sel_mul, 0);
    next_cycle();

    // WAW: second mul to x15 waits until the first has retired
    drive(1'b1, 1'b1, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    #4; check("t7_waw_stall", dec_stall, 1); check("t7_waw_cause", stall_cause, 1);
    check("t7_waw_issue", mul_issue, 0);
    next_cycle(); next_cycle(); next_cycle(); next_cycle();
    #4; check("t7_waw_go", mul_issue, 1);
    next_cycle(); idle();
    for (int c = 0; c < 4; c++) next_cycle();
    #4; check("t7_cnt_empty", inflight_cnt, 0);
    next_cycle();

    // Mid-flight reset discards three muls without a retire pulse
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 5'(20 + c), 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
    end
    idle();
    #4; check("t8_cnt_pre", inflight_cnt, 3);
    rst = 1'b0;
    #1; check("t8_cnt_rst", inflight_cnt, 0); check("t8_wbsel_rst", wb_sel_mul, 0);
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #4;
      check($sformatf("t8_wbsel_%0d", c), wb_sel_mul, 0);
      check($sformatf("t8_cnt_%0d", c), inflight_cnt, 0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 Parameter MUL_LAT, default 4, SHALL set the fixed multiplier latency in cycles; legal range is 2..8.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 dec_valid  in  1  decode stage holds a valid instruction.
REQ-005 dec_is_m  in  1  that instruction is an M-extension multiply.
REQ-006 dec_rd, dec_rs1, dec_rs2  in  5 each  destination and source register indices.
REQ-007 dec_uses_rs1, dec_uses_rs2  in  1 each  source operand is actually read.
REQ-008 stall_in  in  1  backward stall from the memory stage (dcache miss).
REQ-009 br_kill  in  1  branch taken in execute; squashes the decode instruction.
REQ-010 mul_issue  out  1  launch the decode instruction into the pipelined multiplier this cycle.
REQ-011 mul_advance  out  1  multiplier pipeline enable; equals ~stall_in.
REQ-012 wb_sel_mul  out  1  memory-stage input mux selects the multiplier result.
REQ-013 wb_rd  out  5  destination of the retiring multiply; 0 when wb_sel_mul=0.
REQ-014 dec_stall  out  1  hold the decode stage and insert a bubble into execute.
REQ-015 stall_cause  out  2  0 none, 1 RAW/WAW on an in-flight multiply, 2 writeback-slot collision.
REQ-016 inflight_cnt  out  4  number of valid occupied slots, 0..MUL_LAT.

Function
REQ-017 Slot array 1..MUL_LAT: each slot SHALL hold a valid bit and rd; a multiply issued in cycle t SHALL occupy slot 1 at t+1, and each slot SHALL shift by one per cycle while mul_advance=1.
REQ-018 With stall_in=1, every slot SHALL hold its value and no issue or retire SHALL occur.
REQ-019 wb_sel_mul SHALL be 1 exactly when slot MUL_LAT is valid; that slot SHALL retire (clear) on the next edge with stall_in=0.
REQ-020 hazard_raw = dec_valid & any valid slot k (1..MUL_LAT) with rd!=0 and rd matching (dec_rs1 & dec_uses_rs1) or (dec_rs2 & dec_uses_rs2) or dec_rd (WAW).
REQ-021 hazard_wb = dec_valid & ~dec_is_m & slot MUL_LAT-1 valid; a non-multiply issued now would reach the memory stage in the same cycle as that multiply.
REQ-022 dec_stall = ~br_kill & (hazard_raw | hazard_wb); stall_cause SHALL report RAW (1) when both hazards hold.
REQ-023 mul_issue = dec_valid & dec_is_m & ~dec_stall & ~stall_in & ~br_kill.
REQ-024 br_kill SHALL NOT clear any slot: in-flight multiplies are older than the branch.
REQ-025 Multiply-to-multiply writeback collision is impossible (fixed latency); back-to-back issues SHALL be accepted every cycle.
REQ-026 inflight_cnt SHALL be a registered counter, +1 on issue and -1 on retire, unchanged when both or neither occur; it SHALL never exceed MUL_LAT.
REQ-027 All outputs except mul_advance SHALL be derived from registered state plus current inputs; there SHALL be no combinational path from wb_* outputs back to the inputs.

Reset
REQ-028 While rst=0, all slots SHALL be invalid, inflight_cnt=0, wb_sel_mul=0, wb_rd=0, and mul_issue=0.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight multiplies with no retire pulse.

Configuration
REQ-030 With MUL_SCHED_PERF_EN defined, three 32-bit saturating counters (perf_mul_issued, perf_raw_stall, perf_wb_stall) SHALL be present as outputs, clear on reset, and count issues and stall cycles by cause.
REQ-031 Without MUL_SCHED_PERF_EN, neither the counters nor their ports SHALL exist.

Structure
REQ-032 mul_slot_t (valid, rd) and the stall_cause encoding SHALL be defined in structure_pkg; the MUL_LAT default SHALL be defined in constants_pkg.
REQ-033 The slot array and its counter SHALL form the sub-module mul_slot_tracker; hazard logic SHALL stay in mul_scheduler.

Verification
REQ-034 Single mul x5 issued at cycle 0 -> wb_sel_mul=1 with wb_rd=5 at cycle 4; inflight_cnt sequence 1,1,1,1,0.
REQ-035 mul x5 at cycle 0, add reading x5 at cycle 1 -> dec_stall=1 with cause=1 for cycles 1..4; the add issues at cycle 5.
REQ-036 mul x6 at cycle 0, independent add at cycle 3 -> dec_stall=1 with cause=2 for exactly one cycle; the add issues at cycle 4.
REQ-037 Four back-to-back muls x1..x4 -> mul_issue high for 4 cycles; inflight_cnt=4; retires on x1..x4 in order at cycles 4..7.
REQ-038 stall_in high for 3 cycles while mul x7 sits in slot 2 -> wb for x7 is delayed by exactly 3 cycles; br_kill together with a mul in decode -> mul_issue=0 and existing slots are unchanged.
REQ-039 rst pulsed low with 3 slots valid -> inflight_cnt=0 and no wb_sel_mul pulse afterwards.
